// File: rtl/microwave_controller_pkg.sv
// -----------------------------------------------------------------------------
// microwave_controller_pkg
// Shared definitions for the microwave cook-timer sequencer:
//   - state_t   : 3-bit FSM state encoding (IDLE, LOAD, COOK, PAUSE, DONE)
//   - MAX_DEZ   : largest legal tens-of-seconds digit
//   - MAX_DIGIT : largest legal BCD digit
//   - key_accept: decides whether a keypad digit may be shifted into the entry
// -----------------------------------------------------------------------------
package microwave_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_COOK  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [3:0] MAX_DEZ   = 4'd5;
  localparam logic [3:0] MAX_DIGIT = 4'd9;

  // A key is taken only if it is a real BCD digit and the current unit digit,
  // which moves into the tens-of-seconds slot, is still a legal tens value.
  function automatic logic key_accept(input logic [3:0] digit,
                                      input logic [3:0] cur_uni);
    return (digit <= MAX_DIGIT) && (cur_uni <= MAX_DEZ);
  endfunction

endpackage

// File: rtl/microwave_controller_tick_gen.sv
// -----------------------------------------------------------------------------
// microwave_controller_tick_gen
// Once-per-second prescaler. Counts 0..CLK_DIV-1 while i_run is high, holds
// its value while i_run is low, and returns to 0 on i_clr.
// Ports:
//   clk     in   system clock
//   clear   in   synchronous active-high reset
//   i_run   in   advance the prescaler this cycle
//   i_clr   in   force the prescaler to 0 (wins over i_run)
//   o_tick  out  high while the prescaler sits at CLK_DIV-1 (registered decode)
// -----------------------------------------------------------------------------
module microwave_controller_tick_gen #(
  parameter int CLK_DIV = 100
) (
  input  logic clk,
  input  logic clear,
  input  logic i_run,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (clear || i_clr) begin
      r_cnt <= '0;
    end else if (i_run) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CNT_W'(1);
    end
  end

  assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/microwave_controller.sv
// -----------------------------------------------------------------------------
// microwave_controller
// Top-level sequencer for the microwave cook timer. Collects keypad digits into
// an M:SS preset, pulses load into the external down-counter, issues the
// once-per-second decrement enable, and drives the magnetron / done outputs.
// Every output is a register or a decode of registered state/prescaler.
// Ports:
//   clk          in      system clock
//   clear        in      synchronous active-high reset
//   key_valid    in      one-cycle strobe, key_digit valid
//   key_digit    in [4]  BCD digit pressed
//   start        in      start / resume request
//   stop         in      pause request
//   cancel       in      abort and clear the entry
//   door_closed  in      1 = door closed
//   zero         in      external counter at 0:00
//   uni_sec      out[4]  preset unit seconds
//   dez_sec      out[4]  preset tens of seconds
//   min          out[4]  preset minutes
//   load         out     one-cycle counter load pulse
//   enable       out     one-cycle counter decrement enable
//   mag_on       out     magnetron drive
//   done         out     cook-complete indicator
//   cooking      out     1 in LOAD or COOK
// -----------------------------------------------------------------------------
module microwave_controller
  import microwave_controller_pkg::*;
#(
  parameter int CLK_DIV = 100
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start,
  input  logic       stop,
  input  logic       cancel,
  input  logic       door_closed,
  input  logic       zero,
  output logic [3:0] uni_sec,
  output logic [3:0] dez_sec,
  output logic [3:0] min,
  output logic       load,
  output logic       enable,
  output logic       mag_on,
  output logic       done,
  output logic       cooking
);

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_uni;
  logic [3:0] r_dez;
  logic [3:0] r_min;
  logic       w_tick;
  logic       w_pre_run;
  logic       w_pre_clr;
  logic       w_entry_nz;

  assign w_entry_nz = (r_min != 4'd0) || (r_dez != 4'd0) || (r_uni != 4'd0);

  always_ff @(posedge clk) begin
    if (clear) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start && door_closed && w_entry_nz) w_next = ST_LOAD;
      end
      ST_LOAD: begin
        w_next = ST_COOK;
      end
      ST_COOK: begin
        if (zero)                     w_next = ST_DONE;
        else if (!door_closed || stop) w_next = ST_PAUSE;
      end
      ST_PAUSE: begin
        // stop wins over a simultaneous start
        if (start && door_closed && !stop) w_next = ST_COOK;
      end
      ST_DONE: begin
        if (!door_closed) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
    if (cancel) w_next = ST_IDLE;
  end

  // The prescaler only advances on cycles that stay in COOK, so a pause taken
  // mid-second resumes exactly where it stopped. If the pause coincides with
  // an enable, that second has been consumed, so restart from 0 instead of
  // holding at the terminal count (which would re-issue the enable on resume).
  assign w_pre_run = (r_state == ST_COOK) && (w_next == ST_COOK);
  assign w_pre_clr = cancel || (r_state == ST_LOAD) ||
                     ((r_state == ST_COOK) && w_tick && (w_next != ST_COOK));

  microwave_controller_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk    (clk),
    .clear  (clear),
    .i_run  (w_pre_run),
    .i_clr  (w_pre_clr),
    .o_tick (w_tick)
  );

  // Entry register: shifts left in IDLE, cleared on cancel and on DONE entry.
  always_ff @(posedge clk) begin
    if (clear) begin
      r_min <= 4'd0;
      r_dez <= 4'd0;
      r_uni <= 4'd0;
    end else if (cancel || ((r_state == ST_COOK) && (w_next == ST_DONE))) begin
      r_min <= 4'd0;
      r_dez <= 4'd0;
      r_uni <= 4'd0;
    end else if ((r_state == ST_IDLE) && key_valid && key_accept(key_digit, r_uni)) begin
      r_min <= r_dez;
      r_dez <= r_uni;
      r_uni <= key_digit;
    end
  end

  assign uni_sec = r_uni;
  assign dez_sec = r_dez;
  assign min     = r_min;
  assign load    = (r_state == ST_LOAD);
  assign enable  = (r_state == ST_COOK) && w_tick;
  assign mag_on  = (r_state == ST_COOK);
  assign done    = (r_state == ST_DONE);
  assign cooking = (r_state == ST_LOAD) || (r_state == ST_COOK);

endmodule

// File: tb/tb_microwave_controller.sv
// -----------------------------------------------------------------------------
// tb_microwave_controller
// Directed bench for microwave_controller with CLK_DIV=4 and a behavioural
// seconds down-counter attached (load / enable in, zero out).
// -----------------------------------------------------------------------------
module tb_microwave_controller;

  logic       clk = 1'b0;
  logic       clear;
  logic       key_valid;
  logic [3:0] key_digit;
  logic       start;
  logic       stop;
  logic       cancel;
  logic       door_closed;
  logic       zero;
  logic [3:0] uni_sec;
  logic [3:0] dez_sec;
  logic [3:0] min;
  logic       load;
  logic       enable;
  logic       mag_on;
  logic       done;
  logic       cooking;

  int n_checks = 0;
  int n_errors = 0;
  int n_en;

  always #5 clk = ~clk;

  microwave_controller #(
    .CLK_DIV (4)
  ) dut (
    .clk         (clk),
    .clear       (clear),
    .key_valid   (key_valid),
    .key_digit   (key_digit),
    .start       (start),
    .stop        (stop),
    .cancel      (cancel),
    .door_closed (door_closed),
    .zero        (zero),
    .uni_sec     (uni_sec),
    .dez_sec     (dez_sec),
    .min         (min),
    .load        (load),
    .enable      (enable),
    .mag_on      (mag_on),
    .done        (done),
    .cooking     (cooking)
  );

  // Attached cook counter, kept as total seconds.
  int unsigned r_secs;
  always_ff @(posedge clk) begin
    if (clear)                        r_secs <= 0;
    else if (load)                    r_secs <= min * 60 + dez_sec * 10 + uni_sec;
    else if (enable && (r_secs != 0)) r_secs <= r_secs - 1;
  end
  assign zero = (r_secs == 0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] d);
    key_valid = 1'b1;
    key_digit = d;
    step();
    key_valid = 1'b0;
    key_digit = 4'd0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_cancel();
    cancel = 1'b1;
    step();
    cancel = 1'b0;
  endtask

  function automatic logic [11:0] digits();
    return {min, dez_sec, uni_sec};
  endfunction

  function automatic logic [4:0] flags();
    return {load, enable, mag_on, done, cooking};
  endfunction

  initial begin
    clear = 1'b1; key_valid = 1'b0; key_digit = 4'd0;
    start = 1'b0; stop = 1'b0; cancel = 1'b0; door_closed = 1'b1;
    step();
    step();
    check("reset_digits", digits(), 12'h000);
    check("reset_flags",  flags(),  5'b00000);
    clear = 1'b0;

    // Key entry
    press(4'd1); press(4'd3); press(4'd0);
    check("entry_130", digits(), 12'h130);
    press(4'd7);
    check("entry_307", digits(), 12'h307);
    press(4'd11);
    check("entry_bad_key", digits(), 12'h307);
    do_cancel();
    check("cancel_idle_digits", digits(), 12'h000);

    // Illegal tens digit
    press(4'd0); press(4'd0); press(4'd8);
    press(4'd2);
    check("entry_tens_reject", digits(), 12'h008);
    do_cancel();
    press(4'd0); press(4'd0); press(4'd4);
    press(4'd9);
    check("entry_049", digits(), 12'h049);
    do_cancel();

    // Start with door open in IDLE is ignored
    press(4'd3);
    door_closed = 1'b0;
    pulse_start();
    check("door_open_start_flags", flags(), 5'b00000);
    step();
    check("door_open_start_idle", flags(), 5'b00000);
    door_closed = 1'b1;

    // Full cook run, entry 0:03
    check("run_entry", digits(), 12'h003);
    pulse_start();
    check("run_load_flags", flags(), 5'b10001);
    step();
    for (int i = 0; i < 14; i++) begin
      check($sformatf("run_enable_%0d", i), enable, (i == 3 || i == 7 || i == 11));
      check($sformatf("run_mag_%0d", i),    mag_on, (i <= 12));
      check($sformatf("run_done_%0d", i),   done,   (i == 13));
      check($sformatf("run_load_%0d", i),   load,   1'b0);
      step();
    end
    check("done_digits_clear", digits(), 12'h000);
    pulse_start();
    check("done_ignores_start", flags(), 5'b00010);
    door_closed = 1'b0;
    step();
    check("done_exit_door", flags(), 5'b00000);
    door_closed = 1'b1;

    // Pause / resume, entry 0:05
    press(4'd0); press(4'd0); press(4'd5);
    pulse_start();                  // LOAD
    step(); step(); step();         // COOK, prescaler 0,1,2
    check("pre_stop_cook", flags(), 5'b00101);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("pause_flags", flags(), 5'b00000);
    check("pause_digits_held", digits(), 12'h005);
    n_en = 0;
    for (int i = 0; i < 10; i++) begin
      if (enable || mag_on) n_en++;
      step();
    end
    check("pause_no_enable", n_en, 0);
    pulse_start();
    check("resume_cook_flags", flags(), 5'b00101);
    step();
    check("resume_enable", flags(), 5'b01101);
    step();
    check("resume_secs", r_secs, 4);

    // Door opens in COOK -> PAUSE; start with door open stays paused
    door_closed = 1'b0;
    step();
    check("door_open_pause", flags(), 5'b00000);
    pulse_start();
    check("door_open_resume_block", flags(), 5'b00000);
    door_closed = 1'b1;
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    check("start_stop_pause", flags(), 5'b00000);
    do_cancel();
    check("cancel_pause_digits", digits(), 12'h000);
    pulse_start();
    check("cancel_pause_idle", flags(), 5'b00000);

    // zero and stop in the same cycle -> DONE, entry 0:01
    press(4'd1);
    pulse_start();                       // LOAD
    step(); step(); step(); step(); step();  // COOK prescaler 0..3, then 0
    check("zs_zero_seen", zero, 1'b1);
    check("zs_cooking", flags(), 5'b00101);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("zero_beats_stop", flags(), 5'b00010);
    door_closed = 1'b0;
    step();
    door_closed = 1'b1;
    check("zs_exit_idle", flags(), 5'b00000);

    // clear in the middle of COOK
    press(4'd2);
    pulse_start();
    step(); step();
    check("pre_clear_cook", flags(), 5'b00101);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clear_digits", digits(), 12'h000);
    check("clear_flags", flags(), 5'b00000);
    step();
    check("clear_stays_idle", flags(), 5'b00000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
